sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-requester arbiter and cycle sequencer for the 256K x 16 asynchronous board SRAM. It sits between the keyboard-capture logic (requester 0, scancode writes) and the display/readback logic (requester 1, reads). It drives the host side of the SRAM pin wrapper. It serialises accesses, performs round-robin arbitration and generates WE_N/OE_N/CE_N strobes with a programmable strobe width.

## Interface
- WAIT_CYCLES, 2, clock cycles the strobe (WE_N or OE_N access phase) is held; legal range 1..15
- iCLK  in  1  system clock; all logic on rising edge
- iRST  in  1  reset, synchronous, active-high
- iREQ0, iREQ1  in  1 each  access request; held high until matching oACK
- iWR0, iWR1  in  1 each  1 = write, 0 = read
- iADDR0, iADDR1  in  18 each  word address
- iDATA0, iDATA1  in  16 each  write data
- iBE0, iBE1  in  2 each  byte enables, active-high; bit1 = upper byte, bit0 = lower byte
- oACK0, oACK1  out  1 each  one-cycle completion pulse
- oRDATA  out  16  read data, shared; valid from the oACK cycle of a read; held until the next read capture
- oBUSY  out  1  high whenever state is not IDLE
- oSRAM_ADDR  out  18  to wrapper iADDR
- oSRAM_DATA  out  16  to wrapper iDATA
- iSRAM_DATA  in  16  from wrapper oDATA
- oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N  out  1 each  to the wrapper strobes, active-low

## Operation
- All outputs are registered.
- State machine: IDLE -> SETUP -> STROBE -> RECOVER -> IDLE.
- IDLE: if any iREQ is high, grant one requester and latch its iWR, iADDR, iDATA and iBE into the access registers, then go to SETUP. Otherwise stay.
- Arbitration: a `last` register records the last granted requester.
  - Only one requester high: it wins.
  - Both high: the requester that is not `last` wins.
  - Reset sets `last` = 1, so requester 0 wins the first tie.
- SETUP, one cycle:
  - CE_N=0; ADDR and DATA driven from the latched values.
  - UB_N=~BE[1], LB_N=~BE[0].
  - WE_N=1.
  - OE_N=0 for a read, 1 for a write.
- STROBE, WAIT_CYCLES cycles, counted by a 4-bit counter:
  - Write: WE_N=0.
  - Read: OE_N=0, and iSRAM_DATA is captured into oRDATA on the last STROBE cycle.
- RECOVER, one cycle:
  - WE_N=1, OE_N=1, CE_N=0.
  - ADDR, DATA and UB/LB are held, giving data and address hold after the WE_N rising edge.
  - The granted oACK pulses high for this cycle only.
  - Next state is IDLE.
- After RECOVER, CE_N returns to 1 and UB_N/LB_N return to 1 in IDLE. ADDR and DATA keep their last values.
- Request inputs are ignored outside IDLE. Dropping iREQ mid-access does not abort it: the access completes and oACK still pulses.
- iBE = 2'b00: the full cycle runs with UB_N=LB_N=1 and is acknowledged. No memory change occurs; a read returns undefined data.
- A requester that keeps iREQ high in its oACK cycle is treated as issuing a new request at the following IDLE.

## Timing
- Reset values: state IDLE, `last`=1, counter 0.
  - oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N = 1.
  - oSRAM_ADDR = 0, oSRAM_DATA = 0, oRDATA = 0.
  - oACK0 = oACK1 = 0, oBUSY = 0.
- Reset mid-operation: on the cycle after iRST is sampled high, every output is at its reset value. No oACK is issued and the access is lost; the requester must reissue.
- Latency: request sampled in IDLE at cycle t.
  - SETUP at t+1.
  - STROBE at t+2 .. t+1+W.
  - RECOVER / oACK at t+2+W.
  - IDLE at t+3+W.
- Access period is W+3 cycles. Continuously requesting from both requesters gives strict alternation 0,1,0,1.
- The wrapper tri-states DQ when WE_N=1, so the controller needs no turnaround cycle. OE_N and WE_N are never low in the same cycle.

## Test plan
- Single write: W=2; iREQ0=1, iWR0=1, iADDR0=18'h00010, iDATA0=16'hA55A, iBE0=2'b11.
  - Required: WE_N low for exactly 2 cycles; ADDR=0x00010 and DATA=0xA55A stable from SETUP through RECOVER.
  - Required: oACK0 high 4 cycles after request sample.
- Read back: requester 1 reads 0x00010 using an SRAM behavioural model.
  - Required: OE_N low for 3 cycles (SETUP + 2 STROBE); oRDATA=0xA55A in the oACK1 cycle.
- Tie and fairness: both requesters held high for 4 accesses from reset.
  - Required: grants ordered 0,1,0,1; each oACK exactly one cycle; no overlap of WE_N and OE_N.
- Byte enable: write 16'h1234 with BE=2'b01 to a word containing 16'hFFFF.
  - Required: UB_N=1, LB_N=0 during the access; readback 16'hFF34.
- Reset mid-strobe: assert iRST during the second STROBE cycle of a write.
  - Required: next cycle all strobes are 1 and oBUSY=0; no oACK0 pulse.
  - Required: after release, a tie goes to requester 0.
- WAIT_CYCLES=1 build: repeat the write/read pair.
  - Required: a 4-cycle access period; strobe low for 1 cycle; data correct.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter and strobe sequencer for the 256K x 16 async SRAM.
// Each access runs SETUP, WAIT_CYCLES of STROBE, then RECOVER with a one-cycle ack.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iREQ0,
  input  logic        iREQ1,
  input  logic        iWR0,
  input  logic        iWR1,
  input  logic [17:0] iADDR0,
  input  logic [17:0] iADDR1,
  input  logic [15:0] iDATA0,
  input  logic [15:0] iDATA1,
  input  logic [1:0]  iBE0,
  input  logic [1:0]  iBE1,
  output logic        oACK0,
  output logic        oACK1,
  output logic [15:0] oRDATA,
  output logic        oBUSY,
  output logic [17:0] oSRAM_ADDR,
  output logic [15:0] oSRAM_DATA,
  input  logic [15:0] iSRAM_DATA,
  output logic        oSRAM_WE_N,
  output logic        oSRAM_OE_N,
  output logic        oSRAM_CE_N,
  output logic        oSRAM_UB_N,
  output logic        oSRAM_LB_N
);

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] W_CNT = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          last, last_d;
  logic          grant, grant_d;
  logic          acc_wr, acc_wr_d;
  logic          pick;
  logic          we_n_d, oe_n_d, ce_n_d, ub_n_d, lb_n_d;
  logic          ack0_d, ack1_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] data_d, rdata_d;

  // Lone requester wins; on a tie the one not granted last time wins.
  assign pick = (iREQ0 & iREQ1) ? ~last : iREQ1;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    last_d   = last;
    grant_d  = grant;
    acc_wr_d = acc_wr;
    we_n_d   = oSRAM_WE_N;
    oe_n_d   = oSRAM_OE_N;
    ce_n_d   = oSRAM_CE_N;
    ub_n_d   = oSRAM_UB_N;
    lb_n_d   = oSRAM_LB_N;
    addr_d   = oSRAM_ADDR;
    data_d   = oSRAM_DATA;
    rdata_d  = oRDATA;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    case (state)
      IDLE: begin
        if (iREQ0 | iREQ1) begin
          state_d  = SETUP;
          grant_d  = pick;
          last_d   = pick;
          acc_wr_d = pick ? iWR1 : iWR0;
          addr_d   = pick ? iADDR1 : iADDR0;
          data_d   = pick ? iDATA1 : iDATA0;
          ub_n_d   = ~(pick ? iBE1[1] : iBE0[1]);
          lb_n_d   = ~(pick ? iBE1[0] : iBE0[0]);
          ce_n_d   = 1'b0;
          we_n_d   = 1'b1;
          oe_n_d   = pick ? iWR1 : iWR0;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CW'(1);
        we_n_d  = ~acc_wr;
        oe_n_d  = acc_wr;
      end
      STROBE: begin
        if (cnt == W_CNT) begin
          state_d = RECOVER;
          cnt_d   = '0;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          ack0_d  = ~grant;
          ack1_d  = grant;
          if (!acc_wr) rdata_d = iSRAM_DATA;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RECOVER: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= 1'b1;
      grant      <= 1'b0;
      acc_wr     <= 1'b0;
      oSRAM_WE_N <= 1'b1;
      oSRAM_OE_N <= 1'b1;
      oSRAM_CE_N <= 1'b1;
      oSRAM_UB_N <= 1'b1;
      oSRAM_LB_N <= 1'b1;
      oSRAM_ADDR <= '0;
      oSRAM_DATA <= '0;
      oRDATA     <= '0;
      oACK0      <= 1'b0;
      oACK1      <= 1'b0;
      oBUSY      <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      last       <= last_d;
      grant      <= grant_d;
      acc_wr     <= acc_wr_d;
      oSRAM_WE_N <= we_n_d;
      oSRAM_OE_N <= oe_n_d;
      oSRAM_CE_N <= ce_n_d;
      oSRAM_UB_N <= ub_n_d;
      oSRAM_LB_N <= lb_n_d;
      oSRAM_ADDR <= addr_d;
      oSRAM_DATA <= data_d;
      oRDATA     <= rdata_d;
      oACK0      <= ack0_d;
      oACK1      <= ack1_d;
      oBUSY      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=1 instance,
// each with its own behavioural SRAM; sel chooses which instance the stimulus targets.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [17:0] addr0 = '0, addr1 = '0;
  logic [15:0] data0 = '0, data1 = '0;
  logic [1:0]  be0 = '0, be1 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance A (W=2) and instance B (W=1) signals
  logic        a_ack0, a_ack1, a_busy, a_we, a_oe, a_ce, a_ub, a_lb;
  logic [15:0] a_rdata, a_dout, a_din;
  logic [17:0] a_addr;
  logic        b_ack0, b_ack1, b_busy, b_we, b_oe, b_ce, b_ub, b_lb;
  logic [15:0] b_rdata, b_dout, b_din;
  logic [17:0] b_addr;
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];

  sram_arbiter #(.WAIT_CYCLES(2)) u_dut_a (
    .iCLK(clk), .iRST(rst),
    .iREQ0(req0 & ~sel), .iREQ1(req1 & ~sel), .iWR0(wr0), .iWR1(wr1),
    .iADDR0(addr0), .iADDR1(addr1), .iDATA0(data0), .iDATA1(data1),
    .iBE0(be0), .iBE1(be1),
    .oACK0(a_ack0), .oACK1(a_ack1), .oRDATA(a_rdata), .oBUSY(a_busy),
    .oSRAM_ADDR(a_addr), .oSRAM_DATA(a_dout), .iSRAM_DATA(a_din),
    .oSRAM_WE_N(a_we), .oSRAM_OE_N(a_oe), .oSRAM_CE_N(a_ce),
    .oSRAM_UB_N(a_ub), .oSRAM_LB_N(a_lb)
  );

  sram_arbiter #(.WAIT_CYCLES(1)) u_dut_b (
    .iCLK(clk), .iRST(rst),
    .iREQ0(req0 & sel), .iREQ1(req1 & sel), .iWR0(wr0), .iWR1(wr1),
    .iADDR0(addr0), .iADDR1(addr1), .iDATA0(data0), .iDATA1(data1),
    .iBE0(be0), .iBE1(be1),
    .oACK0(b_ack0), .oACK1(b_ack1), .oRDATA(b_rdata), .oBUSY(b_busy),
    .oSRAM_ADDR(b_addr), .oSRAM_DATA(b_dout), .iSRAM_DATA(b_din),
    .oSRAM_WE_N(b_we), .oSRAM_OE_N(b_oe), .oSRAM_CE_N(b_ce),
    .oSRAM_UB_N(b_ub), .oSRAM_LB_N(b_lb)
  );

  // Behavioural SRAMs: byte-masked write while CE_N and WE_N are low, combinational read
  always @(posedge clk) begin
    if (!a_ce && !a_we) begin
      if (!a_ub) mem_a[a_addr[7:0]][15:8] <= a_dout[15:8];
      if (!a_lb) mem_a[a_addr[7:0]][7:0]  <= a_dout[7:0];
    end
    if (!b_ce && !b_we) begin
      if (!b_ub) mem_b[b_addr[7:0]][15:8] <= b_dout[15:8];
      if (!b_lb) mem_b[b_addr[7:0]][7:0]  <= b_dout[7:0];
    end
  end
  assign a_din = (!a_ce && !a_oe) ? mem_a[a_addr[7:0]] : 16'h0000;
  assign b_din = (!b_ce && !b_oe) ? mem_b[b_addr[7:0]] : 16'h0000;

  // View of the selected instance
  logic        v_ack0, v_ack1, v_busy, v_we, v_oe;
  logic [4:0]  strb;
  logic [15:0] v_rdata, v_dout;
  logic [17:0] v_addr;
  assign v_ack0  = sel ? b_ack0  : a_ack0;
  assign v_ack1  = sel ? b_ack1  : a_ack1;
  assign v_busy  = sel ? b_busy  : a_busy;
  assign v_we    = sel ? b_we    : a_we;
  assign v_oe    = sel ? b_oe    : a_oe;
  assign v_rdata = sel ? b_rdata : a_rdata;
  assign v_dout  = sel ? b_dout  : a_dout;
  assign v_addr  = sel ? b_addr  : a_addr;
  assign strb    = sel ? {b_we, b_oe, b_ce, b_ub, b_lb} : {a_we, a_oe, a_ce, a_ub, a_lb};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One complete access from IDLE, checked cycle by cycle; ends in the following IDLE cycle.
  task automatic access(input int id, input logic wr, input logic [17:0] a, input logic [15:0] d,
                        input logic [1:0] be, input logic [15:0] exp_r, input int w);
    if (id == 0) begin
      req0 = 1'b1; wr0 = wr; addr0 = a; data0 = d; be0 = be;
    end else begin
      req1 = 1'b1; wr1 = wr; addr1 = a; data1 = d; be1 = be;
    end
    step();
    check("setup_strb", 32'(strb), 32'({1'b1, wr, 1'b0, ~be[1], ~be[0]}));
    check("setup_addr", 32'(v_addr), 32'(a));
    if (wr) check("setup_data", 32'(v_dout), 32'(d));
    check("setup_busy", 32'(v_busy), 32'd1);
    for (int k = 0; k < w; k++) begin
      step();
      check("strobe_strb", 32'(strb), 32'({~wr, wr, 1'b0, ~be[1], ~be[0]}));
      check("strobe_addr", 32'(v_addr), 32'(a));
      if (wr) check("strobe_data", 32'(v_dout), 32'(d));
      check("strobe_ack", 32'({v_ack1, v_ack0}), 32'd0);
    end
    step();
    check("recov_strb", 32'(strb), 32'({1'b1, 1'b1, 1'b0, ~be[1], ~be[0]}));
    check("recov_ack", 32'({v_ack1, v_ack0}), (id == 0) ? 32'd1 : 32'd2);
    check("recov_addr", 32'(v_addr), 32'(a));
    if (wr) check("recov_data", 32'(v_dout), 32'(d));
    else    check("recov_rdata", 32'(v_rdata), 32'(exp_r));
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    check("idle_strb", 32'(strb), 32'h1F);
    check("idle_ack", 32'({v_ack1, v_ack0}), 32'd0);
    check("idle_busy", 32'(v_busy), 32'd0);
    check("idle_addr", 32'(v_addr), 32'(a));
  endtask

  int n_ack;
  int order [4];
  int when [4];
  logic got_ack;

  initial begin
    do_reset();
    check("rst_strb", 32'(strb), 32'h1F);
    check("rst_addr", 32'(v_addr), 32'd0);
    check("rst_data", 32'(v_dout), 32'd0);
    check("rst_rdata", 32'(v_rdata), 32'd0);
    check("rst_ack", 32'({v_ack1, v_ack0}), 32'd0);
    check("rst_busy", 32'(v_busy), 32'd0);

    // Single write then readback, W=2
    access(0, 1'b1, 18'h00010, 16'hA55A, 2'b11, 16'h0000, 2);
    access(1, 1'b0, 18'h00010, 16'h0000, 2'b11, 16'hA55A, 2);

    // Lower-byte-only write over 0xFFFF
    access(0, 1'b1, 18'h00020, 16'hFFFF, 2'b11, 16'h0000, 2);
    access(1, 1'b1, 18'h00020, 16'h1234, 2'b01, 16'h0000, 2);
    access(0, 1'b0, 18'h00020, 16'h0000, 2'b11, 16'hFF34, 2);

    // Both requesting continuously from reset: 0,1,0,1 at a 5-cycle period
    do_reset();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 18'h00050; data0 = 16'h0101; be0 = 2'b11;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 18'h00050; data1 = 16'h0000; be1 = 2'b11;
    n_ack = 0;
    for (int cyc = 1; cyc <= 40 && n_ack < 4; cyc++) begin
      step();
      check("tie_we_oe_excl", 32'(v_we | v_oe), 32'd1);
      check("tie_ack_excl", 32'(v_ack0 & v_ack1), 32'd0);
      if (v_ack0 || v_ack1) begin
        order[n_ack] = v_ack1 ? 1 : 0;
        when[n_ack]  = cyc;
        if (v_ack1) check("tie_rdata", 32'(v_rdata), 32'h0101);
        n_ack++;
        if (n_ack == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    check("tie_count", 32'(n_ack), 32'd4);
    if (n_ack == 4) begin
      check("tie_first", 32'(when[0]), 32'd4);
      for (int i = 0; i < 4; i++) check("tie_order", 32'(order[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) check("tie_period", 32'(when[i] - when[i-1]), 32'd5);
    end
    step();
    check("tie_idle_ack", 32'({v_ack1, v_ack0}), 32'd0);

    // Reset during the second STROBE cycle of a write
    req0 = 1'b1; wr0 = 1'b1; addr0 = 18'h00030; data0 = 16'hBEEF; be0 = 2'b11;
    step();
    step();
    step();
    check("mid_strobe_we", 32'(v_we), 32'd0);
    rst = 1'b1;
    req0 = 1'b0;
    step();
    rst = 1'b0;
    check("mid_rst_strb", 32'(strb), 32'h1F);
    check("mid_rst_busy", 32'(v_busy), 32'd0);
    check("mid_rst_ack", 32'({v_ack1, v_ack0}), 32'd0);
    check("mid_rst_addr", 32'(v_addr), 32'd0);
    step();
    check("mid_rst_ack2", 32'({v_ack1, v_ack0}), 32'd0);

    // First tie after that reset goes to requester 0
    req0 = 1'b1; wr0 = 1'b1; addr0 = 18'h00060; data0 = 16'h7777; be0 = 2'b11;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 18'h00061; data1 = 16'h8888; be1 = 2'b11;
    step();
    check("rst_tie_addr", 32'(v_addr), 32'h00060);
    got_ack = 1'b0;
    for (int k = 0; k < 10 && !got_ack; k++) begin
      step();
      if (v_ack0 || v_ack1) begin
        got_ack = 1'b1;
        check("rst_tie_ack", 32'({v_ack1, v_ack0}), 32'd1);
      end
    end
    check("rst_tie_seen", 32'(got_ack), 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    for (int k = 0; k < 12; k++) step();
    check("rst_tie_idle", 32'(v_busy), 32'd0);

    // WAIT_CYCLES=1 instance: write/read pair, 4-cycle access period
    sel = 1'b1;
    step();
    access(0, 1'b1, 18'h00040, 16'h5AA5, 2'b11, 16'h0000, 1);
    access(1, 1'b0, 18'h00040, 16'h0000, 2'b11, 16'h5AA5, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
